// File: rtl/cochlea_pkg.sv
// Shared constants and helpers for the cochlea filter-bank stage.
package cochlea_pkg;

  localparam int N_CH_DEF     = 4;
  localparam int GRAY_W_DEF   = 10;
  localparam int DIV_LOG2_DEF = 1;
  localparam int FB_W_DEF     = 6;
  localparam int LO_BIT_DEF   = 6;

  // Bit positions inside each read_out_* pair
  localparam int RO_EVE = 0;
  localparam int RO_POL = 1;

  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cochlea_stage_if.sv
// Signal bundle between a cochlea stage (slave) and its environment (master).
// CS_PASSTHRU_EN adds the daisy-chain outputs rstb_out and ud_en_out.
interface cochlea_stage_if #(
  parameter int N_CH   = 4,
  parameter int GRAY_W = 10
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              ud_en;
  logic [N_CH-1:0]   comp_high_I;
  logic [N_CH-1:0]   comp_high_Q;
  logic [GRAY_W-1:0] gray_clk;
  logic              div_out;
  logic              sin_out;
  logic              cos_out;
  logic [N_CH-1:0]   fb_I;
  logic [N_CH-1:0]   fb_Q;
  logic [1:0]        read_out_I;
  logic [1:0]        read_out_Q;
  logic [CH_W-1:0]   read_slot;
`ifdef CS_PASSTHRU_EN
  logic              rstb_out;
  logic              ud_en_out;

  modport master (output ud_en, comp_high_I, comp_high_Q,
                  input  gray_clk, div_out, sin_out, cos_out, fb_I, fb_Q,
                         read_out_I, read_out_Q, read_slot, rstb_out, ud_en_out);
  modport slave  (input  ud_en, comp_high_I, comp_high_Q,
                  output gray_clk, div_out, sin_out, cos_out, fb_I, fb_Q,
                         read_out_I, read_out_Q, read_slot, rstb_out, ud_en_out);
`else
  modport master (output ud_en, comp_high_I, comp_high_Q,
                  input  gray_clk, div_out, sin_out, cos_out, fb_I, fb_Q,
                         read_out_I, read_out_Q, read_slot);
  modport slave  (input  ud_en, comp_high_I, comp_high_Q,
                  output gray_clk, div_out, sin_out, cos_out, fb_I, fb_Q,
                         read_out_I, read_out_Q, read_slot);
`endif
endinterface

// File: rtl/cs_chan_slice.sv
// One comparator channel: synchroniser, rising-edge event with polarity tag,
// sticky flags, saturating up/down accumulator and PWM feedback compare.
module cs_chan_slice #(
  parameter int FB_W = 6
) (
  input  logic            clk_master,
  input  logic            rstb,
  input  logic            core_en,
  input  logic            clear,
  input  logic            ud_en,
  input  logic            lo,
  input  logic            comp_high,
  input  logic [FB_W-1:0] pwm_ref,
  output logic            eve,
  output logic            pol,
  output logic            fb
);
  localparam logic [FB_W-1:0] ACC_MID = FB_W'(1) << (FB_W - 1);
  localparam logic [FB_W-1:0] ACC_MAX = '1;

  logic            sync1;
  logic            comp_s;
  logic            comp_prev;
  logic            event_hit;
  logic [FB_W-1:0] acc;

  assign event_hit = core_en & comp_s & ~comp_prev;

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      sync1     <= 1'b0;
      comp_s    <= 1'b0;
      comp_prev <= 1'b0;
      eve       <= 1'b0;
      pol       <= 1'b0;
      acc       <= ACC_MID;
      fb        <= 1'b0;
    end else begin
      sync1  <= comp_high;
      comp_s <= sync1;
      if (core_en)
        comp_prev <= comp_s;
      // a new event on the clearing edge survives; the old content is what gets read
      eve <= event_hit | (eve & ~clear);
      pol <= event_hit ? (lo | (pol & ~clear)) : (pol & ~clear);
      if (core_en && ud_en) begin
        if (comp_s && acc != ACC_MAX)
          acc <= acc + 1'b1;
        else if (!comp_s && acc != '0)
          acc <= acc - 1'b1;
      end
      fb <= (acc > pwm_ref);
    end
  end

endmodule

// File: rtl/cochlea_stage.sv
// Cochlea stage top: gray timebase, quadrature LO, div_out, slot readout mux
// and 2*N_CH channel slices. CS_PASSTHRU_EN adds rstb_out / ud_en_out.
module cochlea_stage
  import cochlea_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int GRAY_W   = GRAY_W_DEF,
  parameter int DIV_LOG2 = DIV_LOG2_DEF,
  parameter int FB_W     = FB_W_DEF,
  parameter int LO_BIT   = LO_BIT_DEF
) (
  input  logic            clk_master,
  input  logic            rstb,
  cochlea_stage_if.slave  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NS   = 1 << CH_W;

  logic [GRAY_W-1:0] bin;
  logic [GRAY_W-1:0] bin_next;
  logic              core_en;
  logic [CH_W-1:0]   slot;
  // padded to a power of two so every slot index selects a defined flag
  logic [NS-1:0]     eve_I, pol_I, eve_Q, pol_Q;
  logic [N_CH-1:0]   fb_I_v, fb_Q_v;

  assign bin_next = bin + 1'b1;
  assign core_en  = &bin[DIV_LOG2-1:0];
  assign slot     = bin[CH_W+DIV_LOG2-1:DIV_LOG2];
  assign bus.fb_I = fb_I_v;
  assign bus.fb_Q = fb_Q_v;

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      bin            <= '0;
      bus.gray_clk   <= '0;
      bus.div_out    <= 1'b0;
      bus.sin_out    <= 1'b0;
      bus.cos_out    <= 1'b0;
      bus.read_out_I <= '0;
      bus.read_out_Q <= '0;
      bus.read_slot  <= '0;
    end else begin
      bin          <= bin_next;
      bus.gray_clk <= GRAY_W'(to_gray(32'(bin_next)));
      bus.div_out  <= bus.div_out ^ core_en;
      bus.sin_out  <= bin[LO_BIT];
      bus.cos_out  <= bin[LO_BIT] ^ bin[LO_BIT-1];
      if (core_en) begin
        bus.read_out_I[RO_EVE] <= eve_I[slot];
        bus.read_out_I[RO_POL] <= pol_I[slot];
        bus.read_out_Q[RO_EVE] <= eve_Q[slot];
        bus.read_out_Q[RO_POL] <= pol_Q[slot];
        bus.read_slot          <= slot;
      end
    end
  end

  for (genvar i = 0; i < NS; i++) begin : g_ch
    if (i < N_CH) begin : g_live
      logic clr;
      assign clr = core_en && (slot == CH_W'(i));

      cs_chan_slice #(.FB_W(FB_W)) u_slice_i (
        .clk_master (clk_master),
        .rstb       (rstb),
        .core_en    (core_en),
        .clear      (clr),
        .ud_en      (bus.ud_en),
        .lo         (bus.sin_out),
        .comp_high  (bus.comp_high_I[i]),
        .pwm_ref    (bin[FB_W-1:0]),
        .eve        (eve_I[i]),
        .pol        (pol_I[i]),
        .fb         (fb_I_v[i])
      );

      cs_chan_slice #(.FB_W(FB_W)) u_slice_q (
        .clk_master (clk_master),
        .rstb       (rstb),
        .core_en    (core_en),
        .clear      (clr),
        .ud_en      (bus.ud_en),
        .lo         (bus.cos_out),
        .comp_high  (bus.comp_high_Q[i]),
        .pwm_ref    (bin[FB_W-1:0]),
        .eve        (eve_Q[i]),
        .pol        (pol_Q[i]),
        .fb         (fb_Q_v[i])
      );
    end else begin : g_pad
      assign eve_I[i] = 1'b0;
      assign pol_I[i] = 1'b0;
      assign eve_Q[i] = 1'b0;
      assign pol_Q[i] = 1'b0;
    end
  end

`ifdef CS_PASSTHRU_EN
  logic rst_s1;

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      rst_s1        <= 1'b0;
      bus.rstb_out  <= 1'b0;
      bus.ud_en_out <= 1'b0;
    end else begin
      rst_s1        <= 1'b1;
      bus.rstb_out  <= rst_s1;
      bus.ud_en_out <= bus.ud_en;
    end
  end
`endif

endmodule

// File: tb/tb_cochlea_stage.sv
// Self-checking bench for cochlea_stage: timebase table, hand-timed corner
// sequences and random comparator activity against an arithmetic model.
`timescale 1ns/1ps
module tb_cochlea_stage;
  import cochlea_pkg::*;

  localparam int N_CH     = 4;
  localparam int GRAY_W   = 10;
  localparam int DIV_LOG2 = 1;
  localparam int FB_W     = 6;
  localparam int LO_BIT   = 6;
  localparam int P        = 1 << DIV_LOG2;
  localparam int ACC_MAX  = (1 << FB_W) - 1;

  logic clk_master = 1'b0;
  logic rstb       = 1'b0;

  cochlea_stage_if #(.N_CH(N_CH), .GRAY_W(GRAY_W)) bus ();

  cochlea_stage #(
    .N_CH(N_CH), .GRAY_W(GRAY_W), .DIV_LOG2(DIV_LOG2), .FB_W(FB_W), .LO_BIT(LO_BIT)
  ) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .bus        (bus)
  );

  always #5 clk_master = ~clk_master;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n counts rising edges since reset release; everything is derived from it.
  int              n;
  logic [N_CH-1:0] hist_I [32];
  logic [N_CH-1:0] hist_Q [32];
  logic [N_CH-1:0] m_eve_I, m_pol_I, m_eve_Q, m_pol_Q, m_fb_I, m_fb_Q;
  int              acc_I [N_CH];
  int              acc_Q [N_CH];
  logic [1:0]      m_ro_I, m_ro_Q;
  int              m_slot;
  logic            m_ud_prev;

  function automatic logic h_at(input bit q, input int j, input int c);
    if (j < 1) return 1'b0;
    return q ? hist_Q[j % 32][c] : hist_I[j % 32][c];
  endfunction

  task automatic model_reset();
    n = 0;
    m_eve_I = '0; m_pol_I = '0; m_eve_Q = '0; m_pol_Q = '0;
    m_fb_I = '0;  m_fb_Q = '0;
    m_ro_I = '0;  m_ro_Q = '0;  m_slot = 0; m_ud_prev = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      acc_I[c] = 1 << (FB_W - 1);
      acc_Q[c] = 1 << (FB_W - 1);
    end
  endtask

  task automatic model_step();
    int k, slot, pwm;
    logic core, lo_s, lo_c, s, pv;
    k = n + 1;
    hist_I[k % 32] = bus.comp_high_I;
    hist_Q[k % 32] = bus.comp_high_Q;
    core = ((k % P) == 0);
    slot = ((k - 1) / P) % N_CH;
    pwm  = (k - 1) % (1 << FB_W);
    lo_s = (k >= 2) ? 1'(((k - 2) >> LO_BIT) & 1) : 1'b0;
    lo_c = (k >= 2) ? 1'((((k - 2) >> LO_BIT) ^ ((k - 2) >> (LO_BIT - 1))) & 1) : 1'b0;
    if (core) begin
      m_ro_I = {m_pol_I[slot], m_eve_I[slot]};
      m_ro_Q = {m_pol_Q[slot], m_eve_Q[slot]};
      m_slot = slot;
      m_eve_I[slot] = 1'b0; m_pol_I[slot] = 1'b0;
      m_eve_Q[slot] = 1'b0; m_pol_Q[slot] = 1'b0;
    end
    for (int c = 0; c < N_CH; c++) begin
      s  = h_at(1'b0, k - 2, c);
      pv = h_at(1'b0, k - 2 - P, c);
      if (core && s && !pv) begin m_eve_I[c] = 1'b1; m_pol_I[c] = m_pol_I[c] | lo_s; end
      m_fb_I[c] = (acc_I[c] > pwm);
      if (core && bus.ud_en)
        acc_I[c] = s ? ((acc_I[c] < ACC_MAX) ? acc_I[c] + 1 : ACC_MAX)
                     : ((acc_I[c] > 0) ? acc_I[c] - 1 : 0);
      s  = h_at(1'b1, k - 2, c);
      pv = h_at(1'b1, k - 2 - P, c);
      if (core && s && !pv) begin m_eve_Q[c] = 1'b1; m_pol_Q[c] = m_pol_Q[c] | lo_c; end
      m_fb_Q[c] = (acc_Q[c] > pwm);
      if (core && bus.ud_en)
        acc_Q[c] = s ? ((acc_Q[c] < ACC_MAX) ? acc_Q[c] + 1 : ACC_MAX)
                     : ((acc_Q[c] > 0) ? acc_Q[c] - 1 : 0);
    end
    m_ud_prev = bus.ud_en;
    n = k;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_master or negedge rstb);
      if (!rstb) model_reset();
      else       model_step();
    end
  end

  // ---------------- continuous output checker ----------------
  bit                chk_on = 1'b0;
  logic [GRAY_W-1:0] prev_gray = '0;
  int                prev_n = -10;

  initial forever begin
    int b, v;
    @(negedge clk_master);
    if (chk_on) begin
      b = n % (1 << GRAY_W);
      v = n - 1;
      check("gray_clk", 32'(bus.gray_clk), 32'(b ^ (b >> 1)));
      if (n >= 1 && prev_n == n - 1)
        check("gray_one_bit", $countones(bus.gray_clk ^ prev_gray), 1);
      check("div_out", 32'(bus.div_out), 32'((n / P) % 2));
      check("sin_out", 32'(bus.sin_out), (n >= 1) ? 32'((v >> LO_BIT) & 1) : 0);
      check("cos_out", 32'(bus.cos_out),
            (n >= 1) ? 32'(((v >> LO_BIT) ^ (v >> (LO_BIT - 1))) & 1) : 0);
      check("fb_I", 32'(bus.fb_I), 32'(m_fb_I));
      check("fb_Q", 32'(bus.fb_Q), 32'(m_fb_Q));
      check("read_out_I", 32'(bus.read_out_I), 32'(m_ro_I));
      check("read_out_Q", 32'(bus.read_out_Q), 32'(m_ro_Q));
      check("read_slot", 32'(bus.read_slot), 32'(m_slot));
`ifdef CS_PASSTHRU_EN
      check("ud_en_out", 32'(bus.ud_en_out), 32'(m_ud_prev));
      check("rstb_out", 32'(bus.rstb_out), (n >= 2) ? 1 : 0);
`endif
      prev_gray = bus.gray_clk;
      prev_n    = n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_master); #1;
      if (n % P == 0) bus.ud_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0)
        bus.comp_high_I = bus.comp_high_I ^ (N_CH'(1) << $urandom_range(0, N_CH - 1));
      if ($urandom_range(0, 5) == 0)
        bus.comp_high_Q = bus.comp_high_Q ^ (N_CH'(1) << $urandom_range(0, N_CH - 1));
    end
  endtask

  typedef struct {
    int                cyc;
    logic [GRAY_W-1:0] gray;
    logic              div;
  } tb_vec_t;

  tb_vec_t tbl [11];

  initial begin
    int   guard, cnt, cnt_i;
    bit   found;
    logic seq [8];

    tbl[0]  = '{0,    10'd0,   1'b0};
    tbl[1]  = '{1,    10'd1,   1'b0};
    tbl[2]  = '{2,    10'd3,   1'b1};
    tbl[3]  = '{3,    10'd2,   1'b1};
    tbl[4]  = '{4,    10'd6,   1'b0};
    tbl[5]  = '{5,    10'd7,   1'b0};
    tbl[6]  = '{6,    10'd5,   1'b1};
    tbl[7]  = '{7,    10'd4,   1'b1};
    tbl[8]  = '{1023, 10'd512, 1'b1};
    tbl[9]  = '{1024, 10'd0,   1'b0};
    tbl[10] = '{1025, 10'd1,   1'b0};
    seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.ud_en = 1'b0;
    bus.comp_high_I = '0;
    bus.comp_high_Q = '0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk_master);
    #1 rstb = 1'b1;

    // timebase table: gray sequence, wrap and div_out
    for (int i = 0; i < 11; i++) begin
      guard = 0;
      while (n < tbl[i].cyc && guard < 3000) begin @(negedge clk_master); guard++; end
      check("tbl_cycle", 32'(n), 32'(tbl[i].cyc));
      check("tbl_gray", 32'(bus.gray_clk), 32'(tbl[i].gray));
      check("tbl_div", 32'(bus.div_out), 32'(tbl[i].div));
    end

    // single event on I[2] while sin_out is high
    guard = 0;
    while (bus.sin_out !== 1'b1 && guard < 300) begin @(negedge clk_master); guard++; end
    check("t2_sin_high", 32'(bus.sin_out), 1);
    #1 bus.comp_high_I[2] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk_master);
      if (bus.read_slot == 2 && bus.read_out_I == 2'b11) found = 1'b1;
    end
    check("t2_event_read", 32'(found), 1);
    guard = 0;
    while (bus.read_slot == 2 && guard < 40) begin @(negedge clk_master); guard++; end
    while (bus.read_slot != 2 && guard < 40) begin @(negedge clk_master); guard++; end
    check("t2_next_visit_slot", 32'(bus.read_slot), 2);
    check("t2_next_visit_clear", 32'(bus.read_out_I), 0);
    #1 bus.comp_high_I[2] = 1'b0;

    // set and clear of channel 1 on the same edge
    guard = 0;
    while (n % 8 != 3 && guard < 20) begin @(negedge clk_master); guard++; end
    #1 bus.comp_high_I[1] = seq[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_master); #1 bus.comp_high_I[1] = seq[i];
    end
    @(negedge clk_master);
    @(negedge clk_master);
    check("t3_collide_slot", 32'(bus.read_slot), 1);
    check("t3_collide_eve", 32'(bus.read_out_I[RO_EVE]), 1);
    repeat (8) @(negedge clk_master);
    check("t3_next_slot", 32'(bus.read_slot), 1);
    check("t3_next_eve", 32'(bus.read_out_I[RO_EVE]), 1);
    #1 bus.comp_high_I[1] = 1'b0;

    // feedback saturation high on Q[0], low on all I channels
    @(negedge clk_master); #1;
    bus.ud_en = 1'b1;
    bus.comp_high_Q[0] = 1'b1;
    repeat (80) @(negedge clk_master);
    cnt = 0; cnt_i = 0;
    repeat (64) begin
      @(negedge clk_master);
      cnt   += int'(bus.fb_Q[0]);
      cnt_i += int'(bus.fb_I[0]);
    end
    check("t4_duty_max", 32'(cnt), 63);
    check("t4_duty_zero", 32'(cnt_i), 0);
    #1 bus.ud_en = 1'b0;
    bus.comp_high_Q[0] = 1'b0;
    repeat (40) @(negedge clk_master);
    cnt = 0;
    repeat (64) begin @(negedge clk_master); cnt += int'(bus.fb_Q[0]); end
    check("t4_duty_frozen", 32'(cnt), 63);

    run_random(1500);

    // reset between flag set and readout
    @(negedge clk_master); #1;
    bus.comp_high_I = '0; bus.comp_high_Q = '0;
    repeat (8) @(negedge clk_master);
    #1 bus.comp_high_I = '1; bus.comp_high_Q = '1;
    repeat (4) @(negedge clk_master);
    #2 rstb = 1'b0;
    #1;
    check("t5_gray", 32'(bus.gray_clk), 0);
    check("t5_div", 32'(bus.div_out), 0);
    check("t5_sin_cos", 32'({bus.sin_out, bus.cos_out}), 0);
    check("t5_fb", 32'({bus.fb_I, bus.fb_Q}), 0);
    check("t5_read", 32'({bus.read_out_I, bus.read_out_Q, bus.read_slot}), 0);
    bus.comp_high_I = '0; bus.comp_high_Q = '0; bus.ud_en = 1'b0;
    repeat (3) @(negedge clk_master);
    #1 rstb = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk_master);
      if (bus.read_out_I != 2'b00 || bus.read_out_Q != 2'b00) cnt++;
    end
    check("t5_no_stale", 32'(cnt), 0);

    run_random(400);

    @(negedge clk_master);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
